// File: rtl/sparse_word_packer.sv
// Zero-value-compression packer: streams non-zero bytes into dense activation words and groups masks into mask words.
// Optional non-zero statistics counter enabled by defining PACKER_STATS_EN.
module sparse_word_packer #(
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned LANES            = 16,
  parameter int unsigned ADDR_WIDTH_ACT   = 14,
  parameter int unsigned ADDR_WIDTH_MASKS = 11
) (
  input  logic                          clk,
  input  logic                          arst_n_in,
  input  logic                          clear_in,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES-1:0]              masks_in,
  input  logic [LANES*DATA_WIDTH-1:0]   encoded_in,
  input  logic                          last_in,
  output logic                          act_we,
  output logic [ADDR_WIDTH_ACT-1:0]     act_addr,
  output logic [LANES*DATA_WIDTH-1:0]   act_wdata,
  output logic                          mask_we,
  output logic [ADDR_WIDTH_MASKS-1:0]   mask_addr,
  output logic [LANES*DATA_WIDTH-1:0]   mask_wdata,
  output logic                          done_out,
  output logic [31:0]                   nz_count_out
);

  localparam int unsigned MEM_BW = LANES * DATA_WIDTH;
  localparam int unsigned CNT_W  = $clog2(LANES + 1);
  localparam int unsigned FILL_W = $clog2(LANES);
  localparam int unsigned SUM_W  = $clog2(2 * LANES);
  localparam int unsigned SLOT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic {RUN, FLUSH} state_e;

  state_e                  state_q, state_d;
  logic                    in_ready_q, in_ready_d;
  logic [MEM_BW-1:0]       buf_q, buf_d;
  logic [FILL_W-1:0]       fill_q, fill_d;
  logic [MEM_BW-1:0]       mbuf_q, mbuf_d;
  logic [SLOT_W-1:0]       mslot_q, mslot_d;
  logic [ADDR_WIDTH_ACT-1:0]   act_cnt_q, act_cnt_d;
  logic [ADDR_WIDTH_MASKS-1:0] mask_cnt_q, mask_cnt_d;
  logic                    act_we_q, act_we_d;
  logic [ADDR_WIDTH_ACT-1:0]   act_addr_q, act_addr_d;
  logic [MEM_BW-1:0]       act_wdata_q, act_wdata_d;
  logic                    mask_we_q, mask_we_d;
  logic [ADDR_WIDTH_MASKS-1:0] mask_addr_q, mask_addr_d;
  logic [MEM_BW-1:0]       mask_wdata_q, mask_wdata_d;
  logic                    done_q, done_d;

  logic [CNT_W-1:0]        pop_c;
  logic                    accept_c;
  logic [MEM_BW-1:0]       keep_c;
  logic [2*MEM_BW-1:0]     cat_c;
  logic [SUM_W-1:0]        sum_c;
  logic [MEM_BW-1:0]       mins_c;

  always_comb begin : popcount
    pop_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      pop_c = pop_c + CNT_W'(masks_in[i]);
    end
  end

  assign accept_c = in_valid && in_ready_q;
  // Don't-care bytes past the popcount are masked off so the residual stays zero-padded
  assign keep_c   = ~({MEM_BW{1'b1}} >> (32'(pop_c) * DATA_WIDTH));
  assign cat_c    = {buf_q, {MEM_BW{1'b0}}}
                  | ({encoded_in & keep_c, {MEM_BW{1'b0}}} >> (32'(fill_q) * DATA_WIDTH));
  assign sum_c    = SUM_W'(fill_q) + SUM_W'(pop_c);
  assign mins_c   = {masks_in, {(MEM_BW - LANES){1'b0}}} >> (32'(mslot_q) * LANES);

  always_comb begin : next_state
    state_d      = state_q;
    buf_d        = buf_q;
    fill_d       = fill_q;
    mbuf_d       = mbuf_q;
    mslot_d      = mslot_q;
    act_cnt_d    = act_cnt_q;
    mask_cnt_d   = mask_cnt_q;
    act_we_d     = 1'b0;
    act_addr_d   = act_addr_q;
    act_wdata_d  = act_wdata_q;
    mask_we_d    = 1'b0;
    mask_addr_d  = mask_addr_q;
    mask_wdata_d = mask_wdata_q;
    done_d       = 1'b0;

    if (clear_in) begin
      state_d    = RUN;
      buf_d      = '0;
      fill_d     = '0;
      mbuf_d     = '0;
      mslot_d    = '0;
      act_cnt_d  = '0;
      mask_cnt_d = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (accept_c) begin
            if (sum_c >= SUM_W'(LANES)) begin
              act_we_d    = 1'b1;
              act_addr_d  = act_cnt_q;
              act_wdata_d = cat_c[2*MEM_BW-1 -: MEM_BW];
              act_cnt_d   = act_cnt_q + 1'b1;
              buf_d       = cat_c[MEM_BW-1:0];
              fill_d      = FILL_W'(sum_c - SUM_W'(LANES));
            end else begin
              buf_d  = cat_c[2*MEM_BW-1 -: MEM_BW];
              fill_d = FILL_W'(sum_c);
            end
            if (mslot_q == SLOT_W'(DATA_WIDTH - 1)) begin
              mask_we_d    = 1'b1;
              mask_addr_d  = mask_cnt_q;
              mask_wdata_d = mbuf_q | mins_c;
              mask_cnt_d   = mask_cnt_q + 1'b1;
              mbuf_d       = '0;
              mslot_d      = '0;
            end else begin
              mbuf_d  = mbuf_q | mins_c;
              mslot_d = mslot_q + 1'b1;
            end
            if (last_in) begin
              state_d = FLUSH;
            end
          end
        end
        FLUSH: begin
          if (fill_q != '0) begin
            act_we_d    = 1'b1;
            act_addr_d  = act_cnt_q;
            act_wdata_d = buf_q;
            act_cnt_d   = act_cnt_q + 1'b1;
          end
          if (mslot_q != '0) begin
            mask_we_d    = 1'b1;
            mask_addr_d  = mask_cnt_q;
            mask_wdata_d = mbuf_q;
            mask_cnt_d   = mask_cnt_q + 1'b1;
          end
          buf_d   = '0;
          fill_d  = '0;
          mbuf_d  = '0;
          mslot_d = '0;
          done_d  = 1'b1;
          state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end

    in_ready_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q      <= RUN;
      in_ready_q   <= 1'b0;
      buf_q        <= '0;
      fill_q       <= '0;
      mbuf_q       <= '0;
      mslot_q      <= '0;
      act_cnt_q    <= '0;
      mask_cnt_q   <= '0;
      act_we_q     <= 1'b0;
      act_addr_q   <= '0;
      act_wdata_q  <= '0;
      mask_we_q    <= 1'b0;
      mask_addr_q  <= '0;
      mask_wdata_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      buf_q        <= buf_d;
      fill_q       <= fill_d;
      mbuf_q       <= mbuf_d;
      mslot_q      <= mslot_d;
      act_cnt_q    <= act_cnt_d;
      mask_cnt_q   <= mask_cnt_d;
      act_we_q     <= act_we_d;
      act_addr_q   <= act_addr_d;
      act_wdata_q  <= act_wdata_d;
      mask_we_q    <= mask_we_d;
      mask_addr_q  <= mask_addr_d;
      mask_wdata_q <= mask_wdata_d;
      done_q       <= done_d;
    end
  end

`ifdef PACKER_STATS_EN
  logic [31:0] nz_q, nz_d;
  logic [32:0] nz_sum_c;

  // Saturating count of accepted non-zero elements; flush leaves it alone
  always_comb begin : stats_next
    nz_sum_c = {1'b0, nz_q} + 33'(pop_c);
    nz_d     = nz_q;
    if (clear_in) begin
      nz_d = '0;
    end else if (accept_c) begin
      nz_d = nz_sum_c[32] ? '1 : nz_sum_c[31:0];
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      nz_q <= '0;
    end else begin
      nz_q <= nz_d;
    end
  end

  assign nz_count_out = nz_q;
`else
  assign nz_count_out = 32'd0;
`endif

  assign in_ready   = in_ready_q;
  assign act_we     = act_we_q;
  assign act_addr   = act_addr_q;
  assign act_wdata  = act_wdata_q;
  assign mask_we    = mask_we_q;
  assign mask_addr  = mask_addr_q;
  assign mask_wdata = mask_wdata_q;
  assign done_out   = done_q;

endmodule

// File: tb/tb_sparse_word_packer.sv
// Bench for sparse_word_packer: directed vector table plus random traffic against a queue-based reference model.
module tb_sparse_word_packer;

  logic         clk = 1'b0;
  logic         arst_n_in;
  logic         clear_in;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  masks_in;
  logic [127:0] encoded_in;
  logic         last_in;
  logic         act_we;
  logic [13:0]  act_addr;
  logic [127:0] act_wdata;
  logic         mask_we;
  logic [10:0]  mask_addr;
  logic [127:0] mask_wdata;
  logic         done_out;
  logic [31:0]  nz_count_out;

  int n_tests = 0;
  int n_fail  = 0;

  sparse_word_packer dut (
    .clk          (clk),
    .arst_n_in    (arst_n_in),
    .clear_in     (clear_in),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .masks_in     (masks_in),
    .encoded_in   (encoded_in),
    .last_in      (last_in),
    .act_we       (act_we),
    .act_addr     (act_addr),
    .act_wdata    (act_wdata),
    .mask_we      (mask_we),
    .mask_addr    (mask_addr),
    .mask_wdata   (mask_wdata),
    .done_out     (done_out),
    .nz_count_out (nz_count_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic [15:0]  m;
    logic [127:0] enc;
    logic         last;
    logic         awe;
    logic [13:0]  aad;
    logic [127:0] ad;
    logic         mwe;
    logic [10:0]  mad;
    logic [127:0] md;
    logic         done;
  } vec_t;

  vec_t tv[21];

  // reference model state
  logic [7:0]  bq[$];
  logic [15:0] mq[$];
  int unsigned m_aaddr;
  int unsigned m_maddr;
  longint      m_nz;
  bit          m_flush;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] seq(input logic [7:0] base, input int n);
    logic [127:0] r;
    r = '0;
    for (int j = 0; j < n; j++) r[127-8*j -: 8] = base + 8'(j);
    return r;
  endfunction

  // n sequential bytes, remaining byte slots filled with junk
  function automatic logic [127:0] enc_of(input logic [7:0] base, input int n);
    logic [127:0] r;
    r = seq(base, n);
    for (int j = n; j < 16; j++) r[127-8*j -: 8] = 8'hEE;
    return r;
  endfunction

  function automatic vec_t mk(input logic v, input logic [15:0] m, input logic [127:0] enc,
                              input logic last, input logic awe, input logic [13:0] aad,
                              input logic [127:0] ad, input logic mwe, input logic [10:0] mad,
                              input logic [127:0] md, input logic done);
    vec_t r;
    r.v = v; r.m = m; r.enc = enc; r.last = last; r.awe = awe; r.aad = aad; r.ad = ad;
    r.mwe = mwe; r.mad = mad; r.md = md; r.done = done;
    return r;
  endfunction

  function automatic void model_reset();
    bq.delete();
    mq.delete();
    m_aaddr = 0;
    m_maddr = 0;
    m_nz    = 0;
    m_flush = 0;
  endfunction

  // One clock with the given inputs, then compare against the model
  task automatic cyc(input logic v, input logic [15:0] m, input logic [127:0] e,
                     input logic l, input logic c);
    logic         e_awe, e_mwe, e_done;
    logic [127:0] e_ad, e_md;
    int unsigned  e_aad, e_mad;
    int           p;
    logic [31:0]  e_nz;
    in_valid = v; masks_in = m; encoded_in = e; last_in = l; clear_in = c;
    @(posedge clk);
    #1;
    e_awe = 0; e_mwe = 0; e_done = 0; e_ad = '0; e_md = '0; e_aad = 0; e_mad = 0;
    if (c) begin
      model_reset();
    end else if (m_flush) begin
      if (bq.size() > 0) begin
        e_awe = 1; e_aad = m_aaddr;
        for (int j = 0; j < bq.size(); j++) e_ad[127-8*j -: 8] = bq[j];
        bq.delete();
        m_aaddr = (m_aaddr + 1) % 16384;
      end
      if (mq.size() > 0) begin
        e_mwe = 1; e_mad = m_maddr;
        for (int j = 0; j < mq.size(); j++) e_md[127-16*j -: 16] = mq[j];
        mq.delete();
        m_maddr = (m_maddr + 1) % 2048;
      end
      e_done  = 1;
      m_flush = 0;
    end else if (v) begin
      p = $countones(m);
      for (int j = 0; j < p; j++) bq.push_back(e[127-8*j -: 8]);
      mq.push_back(m);
      m_nz = m_nz + p;
      if (m_nz > 64'hFFFF_FFFF) m_nz = 64'hFFFF_FFFF;
      if (bq.size() >= 16) begin
        e_awe = 1; e_aad = m_aaddr;
        for (int j = 0; j < 16; j++) e_ad[127-8*j -: 8] = bq.pop_front();
        m_aaddr = (m_aaddr + 1) % 16384;
      end
      if (mq.size() == 8) begin
        e_mwe = 1; e_mad = m_maddr;
        for (int j = 0; j < 8; j++) e_md[127-16*j -: 16] = mq.pop_front();
        m_maddr = (m_maddr + 1) % 2048;
      end
      if (l) m_flush = 1;
    end
`ifdef PACKER_STATS_EN
    e_nz = 32'(m_nz);
`else
    e_nz = 32'd0;
`endif
    chk("act_we", 128'(act_we), 128'(e_awe));
    if (e_awe) begin
      chk("act_addr", 128'(act_addr), 128'(e_aad));
      chk("act_wdata", act_wdata, e_ad);
    end
    chk("mask_we", 128'(mask_we), 128'(e_mwe));
    if (e_mwe) begin
      chk("mask_addr", 128'(mask_addr), 128'(e_mad));
      chk("mask_wdata", mask_wdata, e_md);
    end
    chk("done_out", 128'(done_out), 128'(e_done));
    chk("in_ready", 128'(in_ready), 128'(!m_flush));
    chk("nz_count", 128'(nz_count_out), 128'(e_nz));
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    logic [15:0] rm;
    logic [31:0] e19;

    tv[0]  = mk(1, 16'hFFFF, enc_of(8'h01, 16), 0, 1, 14'd0, seq(8'h01, 16), 0, 11'd0, '0, 0);
    tv[1]  = mk(1, 16'hFFFF, enc_of(8'h11, 16), 0, 1, 14'd1, seq(8'h11, 16), 0, 11'd0, '0, 0);
    tv[2]  = mk(1, 16'hFFFF, enc_of(8'h21, 16), 1, 1, 14'd2, seq(8'h21, 16), 0, 11'd0, '0, 0);
    tv[3]  = mk(0, 16'h0000, '0, 0, 0, 14'd0, '0, 1, 11'd0,
                {16'hFFFF, 16'hFFFF, 16'hFFFF, 80'h0}, 1);
    tv[4]  = mk(1, 16'hFFC0, enc_of(8'h01, 10), 0, 0, 14'd0, '0, 0, 11'd0, '0, 0);
    tv[5]  = mk(1, 16'hFFC0, enc_of(8'h0B, 10), 0, 1, 14'd3, seq(8'h01, 16), 0, 11'd0, '0, 0);
    tv[6]  = mk(1, 16'hFFF0, enc_of(8'h15, 12), 1, 1, 14'd4, seq(8'h11, 16), 0, 11'd0, '0, 0);
    tv[7]  = mk(0, 16'h0000, '0, 0, 0, 14'd0, '0, 1, 11'd1,
                {16'hFFC0, 16'hFFC0, 16'hFFF0, 80'h0}, 1);
    tv[8]  = mk(1, 16'h8001, {8'hAA, 8'hBB, {14{8'hEE}}}, 1, 0, 14'd0, '0, 0, 11'd0, '0, 0);
    tv[9]  = mk(0, 16'h0000, '0, 0, 1, 14'd5, {8'hAA, 8'hBB, 112'h0}, 1, 11'd2,
                {16'h8001, 112'h0}, 1);
    for (int i = 10; i < 17; i++)
      tv[i] = mk(1, 16'h0000, {16{8'hEE}}, 0, 0, 14'd0, '0, 0, 11'd0, '0, 0);
    tv[17] = mk(1, 16'h0000, {16{8'hEE}}, 0, 0, 14'd0, '0, 1, 11'd3, '0, 0);
    tv[18] = mk(1, 16'hFFFF, enc_of(8'h40, 16), 0, 1, 14'd6, seq(8'h40, 16), 0, 11'd0, '0, 0);
    tv[19] = mk(1, 16'h0000, {16{8'hEE}}, 1, 0, 14'd0, '0, 0, 11'd0, '0, 0);
    tv[20] = mk(0, 16'h0000, '0, 0, 0, 14'd0, '0, 1, 11'd4, {16'hFFFF, 112'h0}, 1);

    arst_n_in = 0; clear_in = 0; in_valid = 0; masks_in = '0; encoded_in = '0; last_in = 0;
    @(posedge clk);
    #1;
    chk("rst in_ready", 128'(in_ready), 128'(0));
    chk("rst act_we", 128'(act_we), 128'(0));
    chk("rst mask_we", 128'(mask_we), 128'(0));
    chk("rst done", 128'(done_out), 128'(0));
    chk("rst act_addr", 128'(act_addr), 128'(0));
    chk("rst mask_addr", 128'(mask_addr), 128'(0));
    chk("rst act_wdata", act_wdata, 128'(0));
    chk("rst mask_wdata", mask_wdata, 128'(0));
    chk("rst nz", 128'(nz_count_out), 128'(0));
    arst_n_in = 1;
    @(posedge clk);
    #1;
    chk("post-rst in_ready", 128'(in_ready), 128'(1));

    for (int i = 0; i < 21; i++) begin
      in_valid = tv[i].v; masks_in = tv[i].m; encoded_in = tv[i].enc; last_in = tv[i].last;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d act_we", i), 128'(act_we), 128'(tv[i].awe));
      if (tv[i].awe) begin
        chk($sformatf("v%0d act_addr", i), 128'(act_addr), 128'(tv[i].aad));
        chk($sformatf("v%0d act_wdata", i), act_wdata, tv[i].ad);
      end
      chk($sformatf("v%0d mask_we", i), 128'(mask_we), 128'(tv[i].mwe));
      if (tv[i].mwe) begin
        chk($sformatf("v%0d mask_addr", i), 128'(mask_addr), 128'(tv[i].mad));
        chk($sformatf("v%0d mask_wdata", i), mask_wdata, tv[i].md);
      end
      chk($sformatf("v%0d done", i), 128'(done_out), 128'(tv[i].done));
    end

    // random traffic against the model
    model_reset();
    cyc(0, '0, '0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(3))
        0:       rm = 16'h0000;
        1:       rm = 16'hFFFF;
        default: rm = 16'($urandom());
      endcase
      cyc(($urandom_range(3) != 0), rm, rnd128(), ($urandom_range(11) == 0),
          ($urandom_range(199) == 0));
    end

    // activation address wrap
    cyc(0, '0, '0, 0, 1);
    for (int i = 0; i < 16383; i++) cyc(1, 16'hFFFF, rnd128(), 0, 0);
    cyc(1, 16'hFFFF, rnd128(), 0, 0);
    chk("wrap top addr", 128'(act_addr), 128'(14'h3FFF));
    cyc(1, 16'hFFFF, rnd128(), 0, 0);
    chk("wrap zero addr", 128'(act_addr), 128'(0));

    // clear with five bytes buffered
    cyc(1, 16'hF800, rnd128(), 0, 0);
    cyc(1, 16'hFFFF, rnd128(), 1, 1);
    chk("clear no act write", 128'(act_we), 128'(0));
    cyc(1, 16'hFFFF, enc_of(8'h60, 16), 0, 0);
    chk("post-clear addr", 128'(act_addr), 128'(0));
    chk("post-clear data", act_wdata, seq(8'h60, 16));

    // statistics
    cyc(0, '0, '0, 0, 1);
    cyc(1, 16'hFFFF, rnd128(), 0, 0);
    cyc(1, 16'h0007, rnd128(), 0, 0);
    cyc(1, 16'h0000, rnd128(), 0, 0);
`ifdef PACKER_STATS_EN
    e19 = 32'd19;
`else
    e19 = 32'd0;
`endif
    chk("nz after 16+3+0", 128'(nz_count_out), 128'(e19));
    cyc(0, '0, '0, 0, 1);
    chk("nz after clear", 128'(nz_count_out), 128'(0));

    // asynchronous reset mid-tile
    cyc(1, 16'hF800, rnd128(), 0, 0);
    in_valid = 0; last_in = 0; clear_in = 0;
    #2;
    arst_n_in = 0;
    #1;
    chk("async rst act_we", 128'(act_we), 128'(0));
    chk("async rst act_wdata", act_wdata, 128'(0));
    chk("async rst in_ready", 128'(in_ready), 128'(0));
    #2;
    arst_n_in = 1;
    @(posedge clk);
    #1;
    chk("async rst ready back", 128'(in_ready), 128'(1));
    model_reset();
    cyc(1, 16'hFFFF, enc_of(8'h70, 16), 0, 0);
    chk("post-rst write data", act_wdata, seq(8'h70, 16));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sparse_word_packer.md
# sparse_word_packer

Parametrised zero-value-compression packer sitting between the activation encoder and the activation/mask SRAMs. Each input beat carries one group of `LANES` sparsity mask bits and the group's non-zero bytes, compacted MSB-first. The block streams these bytes into dense `MEM_BW`-bit activation words and collects `DATA_WIDTH` masks per mask word. It sustains one beat per cycle through a valid/ready handshake and zero-pads partial words on an end-of-tile flush.

## Interface
Parameters:
- `DATA_WIDTH`, 8: bits per activation element; also the number of masks per mask word.
- `LANES`, 16: elements per group; `MEM_BW = LANES*DATA_WIDTH` (128 by default).
- `ADDR_WIDTH_ACT`, 14: activation SRAM address width.
- `ADDR_WIDTH_MASKS`, 11: mask SRAM address width.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock.
- `arst_n_in` in 1: asynchronous active-low reset.
- `clear_in` in 1: synchronous clear of buffers and address counters.
- `in_valid` in 1: beat valid.
- `in_ready` out 1: beat accepted when `in_valid && in_ready`.
- `masks_in` in LANES: bit i set means lane i is non-zero; lane 0 is the MSB.
- `encoded_in` in MEM_BW: non-zero bytes, first at bits [MEM_BW-1 -: DATA_WIDTH]. Bytes beyond popcount(`masks_in`) are don't-care.
- `last_in` in 1: last beat of the tile; triggers a flush.
- `act_we` out 1; `act_addr` out ADDR_WIDTH_ACT; `act_wdata` out MEM_BW: activation write port.
- `mask_we` out 1; `mask_addr` out ADDR_WIDTH_MASKS; `mask_wdata` out MEM_BW: mask write port.
- `done_out` out 1: one-cycle pulse when a flush completes.
- `nz_count_out` out 32: statistics (see Configuration).

## Operation
- Byte buffer: 2*LANES entries plus fill count `fill` (0..LANES-1 between beats).
  - On accept, p = popcount(`masks_in`) bytes are appended at position `fill`.
  - If fill+p ≥ LANES, the first LANES bytes form an activation write and the remainder shifts to the front; `fill` becomes fill+p−LANES.
  - Otherwise `fill` becomes fill+p.
  - fill+p == LANES exactly gives one write and `fill`=0. p=0 appends nothing but the mask is still recorded.
- Mask buffer: `DATA_WIDTH` slots of LANES bits, slot index `mslot`.
  - Each accepted beat writes `masks_in` to slot `mslot`; slot 0 is at bits [MEM_BW-1 -: LANES].
  - When `mslot` reaches DATA_WIDTH, the full word is written and `mslot` returns to 0.
- Address counters `act_addr` and `mask_addr` increment after each respective write and wrap modulo 2^width. They are not reset by flush.
- FSM states:
  - RUN: `in_ready`=1. An accepted beat with `last_in`=1 moves to FLUSH.
  - FLUSH: `in_ready`=0.
    - If `fill`>0, write the residual bytes MSB-first with the low bytes zero.
    - If `mslot`>0, write the filled mask slots with the remaining slots zero.
    - Each write is skipped independently if its buffer is empty.
    - `fill` and `mslot` clear, `done_out` pulses, and the FSM returns to RUN.
- `clear_in` has the highest priority in any state. It zeroes `fill`, `mslot` and both address counters, forces RUN, produces no writes and suppresses any pending flush. Partial data is discarded.
- No downstream backpressure: the memories accept every write.

## Timing
- Reset values: `in_ready`=0 during reset and 1 in the first cycle after release. `act_we`, `mask_we` and `done_out` are 0. All address and data outputs are 0, and `nz_count_out` is 0.
- All write-port outputs are registered. A beat accepted at edge t drives its writes in cycle t..t+1, with the address pre-increment.
- At most one activation write and one mask write per cycle; both may occur in the same cycle.
- The last beat is accepted at edge t, and FLUSH occupies cycle t..t+1.
  - Flush writes and `done_out` are registered from FLUSH, so they appear in cycle t+1..t+2.
  - `in_ready` returns to 1 in that same cycle.
  - Throughput is LANES per group, with one bubble per tile.
- `done_out` pulses even when the flush writes nothing.
- Reset asserted mid-tile drops all buffered data immediately.

## Configuration
- `PACKER_STATS_EN` defined: `nz_count_out` accumulates p on every accepted beat, saturating at 2^32−1. It is cleared by reset and `clear_in`, not by flush.
- Not defined: no counter logic exists, and `nz_count_out` is tied to 0.

## Test plan
- Dense stream: 3 beats with `masks_in`=16'hFFFF and bytes 0x01..0x30, `last_in` on beat 3.
  - Required: act writes at addr 0,1,2, each containing its own 16 bytes.
  - Required: one padded mask write at addr 0 = {FFFF,FFFF,FFFF,0x0000×5}; `done_out` one cycle after the last write.
- Straddling: beats with p=10, 10, 12 (bytes 1..32) and `last_in` on the third.
  - Required: act write at t+1 of beat 2 = bytes 1..16.
  - Required: act write after beat 3 = bytes 17..32.
  - Required: no residual write in FLUSH.
- Partial flush: one beat with `masks_in`=16'h8001, bytes AA,BB, `last_in`=1.
  - Required: act_wdata = AA BB followed by 14 zero bytes.
  - Required: mask_wdata = 16'h8001 in the MSBs, rest zero.
- Mask word rollover: 8 beats with p=0 and no `last_in`.
  - Required: exactly one mask write on the 8th beat; no act writes; `fill`=0.
- Clear and wrap:
  - Preload `act_addr` to 2^14−1 via writes. The next full word goes to 16383, the following one to 0.
  - `clear_in` mid-tile with `fill`=5: no write, next write at addr 0.
- With `PACKER_STATS_EN`: beats with p=16, 3, 0.
  - Required: `nz_count_out`=19.
  - Required: `nz_count_out`=0 after `clear_in`; it stays 0 when the macro is undefined.
